// File: rtl/simon_ctrl.sv
// Game controller for a Simon memory game: sequences generate/replay/input/validate
// phases, tracks level, press index, lives and the per-press input timeout.
module simon_ctrl #(
    parameter int MAX_LEVEL   = 10,
    parameter int LVL_W       = 4,
    parameter int LIVES       = 3,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_req,
    input  logic             blinker_done,
    input  logic             input_done,
    input  logic             cmp_good,
    output logic             getRandNum,
    output logic             rw_mem,
    output logic             on_cmp,
    output logic             on_input_block,
    output logic             on_blinker,
    output logic [LVL_W-1:0] out_level,
    output logic [LVL_W-1:0] step_idx,
    output logic [3:0]       lives_left,
    output logic             mistake,
    output logic             game_won,
    output logic             game_over
);

    localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(MAX_LEVEL);
    localparam logic [3:0]       LIVES_INI = 4'(LIVES);

    // 4-bit encoding leaves spare codes; any of them falls back to IDLE.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_GEN      = 4'd1,
        S_BLINK    = 4'd2,
        S_INPUT    = 4'd3,
        S_VALIDATE = 4'd4,
        S_FAIL     = 4'd5,
        S_WIN      = 4'd6,
        S_LOSE     = 4'd7
    } state_t;

    state_t           state_q, state_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] step_q, step_d;
    logic [3:0]       lives_q, lives_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            level_q <= '0;
            step_q  <= '0;
            lives_q <= LIVES_INI;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            step_q  <= step_d;
            lives_q <= lives_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        step_d  = step_q;
        lives_d = lives_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                level_d = '0;
                step_d  = '0;
                lives_d = LIVES_INI;
                timer_d = '0;
                if (start_req) state_d = S_GEN;
            end
            S_GEN: begin
                if (level_q < LVL_MAX) level_d = level_q + 1'b1;
                step_d  = '0;
                state_d = S_BLINK;
            end
            S_BLINK: begin
                if (blinker_done) begin
                    state_d = S_INPUT;
                    timer_d = '0;
                end
            end
            S_INPUT: begin
                // A press arriving on the last timeout cycle still counts as a press.
                if (input_done) begin
                    state_d = S_VALIDATE;
                    if (step_q < level_q) step_d = step_q + 1'b1;
                    timer_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_FAIL;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_VALIDATE: begin
                if (!cmp_good) begin
                    state_d = S_FAIL;
                end else if (step_q < level_q) begin
                    state_d = S_INPUT;
                    timer_d = '0;
                end else if (level_q < LVL_MAX) begin
                    state_d = S_GEN;
                end else begin
                    state_d = S_WIN;
                end
            end
            S_FAIL: begin
                if (lives_q != 4'd0) lives_d = lives_q - 4'd1;
                step_d  = '0;
                state_d = (lives_q <= 4'd1) ? S_LOSE : S_BLINK;
            end
            S_WIN, S_LOSE: begin
                // Clear counters on exit so IDLE shows a fresh game immediately.
                if (start_req) begin
                    state_d = S_IDLE;
                    level_d = '0;
                    step_d  = '0;
                    lives_d = LIVES_INI;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                level_d = '0;
                step_d  = '0;
                lives_d = LIVES_INI;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        getRandNum     = 1'b0;
        rw_mem         = 1'b0;
        on_cmp         = 1'b0;
        on_input_block = 1'b0;
        on_blinker     = 1'b0;
        mistake        = 1'b0;
        game_won       = 1'b0;
        game_over      = 1'b0;
        out_level      = '0;
        case (state_q)
            S_GEN: begin
                getRandNum = 1'b1;
                rw_mem     = 1'b1;
                out_level  = level_q;
            end
            S_BLINK: begin
                on_blinker = 1'b1;
                out_level  = level_q;
            end
            S_INPUT: begin
                on_input_block = 1'b1;
                out_level      = step_q;
            end
            S_VALIDATE: begin
                on_cmp    = 1'b1;
                out_level = step_q;
            end
            S_FAIL: begin
                mistake   = 1'b1;
                out_level = level_q;
            end
            S_WIN: begin
                game_won  = 1'b1;
                out_level = level_q;
            end
            S_LOSE: begin
                game_over = 1'b1;
                out_level = level_q;
            end
            default: out_level = '0;
        endcase
    end

    assign step_idx   = step_q;
    assign lives_left = lives_q;

endmodule

// File: doc/simon_ctrl.md
SIMON_CTRL -- requirements
Module: simon_ctrl

Interface
REQ-001 Parameter MAX_LEVEL, default 10: level that wins the game; legal range 1..2^LVL_W-1.
REQ-002 Parameter LVL_W, default 4: width of level and step counters.
REQ-003 Parameter LIVES, default 3: mistakes tolerated before loss; legal range 1..15.
REQ-004 Parameter TIMEOUT_CYC, default 50000000: input-wait cycles before a timeout counts as a mistake; legal value >=2.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-007 start_req  in  1  level-sensitive request to begin, or restart, a game.
REQ-008 blinker_done  in  1  blinker has finished replaying the sequence.
REQ-009 input_done  in  1  one player press has been captured.
REQ-010 cmp_good  in  1  captured press matches the stored element.
REQ-011 getRandNum, rw_mem, on_cmp, on_input_block, on_blinker  out  1 each  datapath enables.
REQ-012 out_level  out  LVL_W  display value.
REQ-013 step_idx  out  LVL_W  sequence index of the current press; equals step.
REQ-014 lives_left  out  4  remaining lives.
REQ-015 mistake  out  1  one-cycle pulse per mistake.
REQ-016 game_won, game_over  out  1 each  terminal-state flags.

Function
REQ-017 States: IDLE, GEN, BLINK, INPUT, VALIDATE, FAIL, WIN, LOSE; state, level, step, lives and timer are registered.
REQ-018 IDLE: level=0, step=0, lives=LIVES; start_req=1 -> GEN, otherwise stay.
REQ-019 GEN lasts one cycle: level<=level+1, step<=0 -> BLINK.
REQ-020 BLINK: blinker_done=1 -> INPUT with timer<=0; otherwise stay.
REQ-021 INPUT: input_done=1 -> VALIDATE, step<=step+1, timer<=0.
REQ-022 INPUT without input_done: timer increments; at timer==TIMEOUT_CYC-1 -> FAIL.
REQ-023 INPUT with input_done and the timeout condition in the same cycle: input_done wins.
REQ-024 VALIDATE lasts one cycle; cmp_good=0 -> FAIL.
REQ-025 VALIDATE with cmp_good=1 and step<level -> INPUT, timer<=0.
REQ-026 VALIDATE with cmp_good=1, step==level and level<MAX_LEVEL -> GEN.
REQ-027 VALIDATE with cmp_good=1, step==level and level==MAX_LEVEL -> WIN.
REQ-028 FAIL lasts one cycle: lives<=lives-1, mistake=1, step<=0; lives==1 on entry -> LOSE, otherwise -> BLINK with the same level and sequence.
REQ-029 WIN and LOSE hold until start_req=1, then -> IDLE; start_req held high therefore starts a new game on the next cycle.
REQ-030 Outputs are Moore-decoded from state in the order {getRandNum, rw_mem, on_cmp, on_input_block, on_blinker}: GEN=11000, BLINK=00001, INPUT=00010, VALIDATE=00100, all other states=00000.
REQ-031 out_level = level in GEN, BLINK, FAIL, WIN and LOSE; = step in INPUT and VALIDATE; = 0 in IDLE.
REQ-032 game_won=1 only in WIN; game_over=1 only in LOSE; lives_left = lives.
REQ-033 An unreachable state encoding recovers to IDLE on the next clock, with all enables 0 meanwhile.
REQ-034 Counters never wrap: level never exceeds MAX_LEVEL, step never exceeds level, lives never go below 0.

Reset
REQ-035 reset=0 at any rising edge, in any state including mid-game: state=IDLE, level=0, step=0, lives=LIVES, timer=0 on the next cycle; reset overrides all inputs.
REQ-036 During and after reset, until start_req: all enables 0, mistake=0, game_won=0, game_over=0, out_level=0, lives_left=LIVES.

Verification (MAX_LEVEL=3, LIVES=2, TIMEOUT_CYC=8)
REQ-037 Start game, blinker_done after 2 cycles, correct press -> GEN->BLINK->INPUT->VALIDATE->GEN; level becomes 2; getRandNum high for exactly one cycle each time.
REQ-038 All presses correct through level 3 -> WIN with game_won=1 and out_level=3; start_req -> IDLE, then GEN with level=1.
REQ-039 Wrong press at level 2, step 1 -> FAIL with mistake pulse, lives_left=1, then BLINK at level 2 with step_idx=0; second wrong press -> LOSE with game_over=1.
REQ-040 No press in INPUT for 8 cycles -> FAIL on cycle 8; input_done coincident with cycle 8 -> VALIDATE instead.
REQ-041 reset=0 during INPUT at level 2 -> next cycle IDLE, outputs per REQ-036; start_req -> level=1.
REQ-042 Parameters MAX_LEVEL=15, LVL_W=4 -> level reaches 15 and WIN with no wrap; assertion that step<=level in every cycle.
